frame_stream_controller: RTL
============================

Name: frame_stream_controller

Overview:
- Sequences one full-frame pass of the border-detection datapath: reads the input frame RAM in raster order and streams pixels into the processing kernel over valid/ready.
- Collects the kernel's output stream and writes it to the output frame RAM, optionally zeroing the 1-pixel image border.
- Reports start-to-done cycle count for throughput measurement.
- Sits between the frame memories and ImageProcessing; replaces whole-array port access with a streamed interface.

Parameters:
- WIDTH, 320, image width in pixels
- HEIGHT, 240, image height in pixels
- PIX_W, 8, pixel width in bits
- ADDR_W, 17, frame address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle frame start request
- zero_border  in  1  force border outputs to 0; sampled at accepted start
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when frame is fully written
- cycle_count  out  32  cycles spent in RUN+DRAIN for the last/current frame
- src_re  out  1  input RAM read enable
- src_addr  out  ADDR_W  input RAM read address
- src_rdata  in  PIX_W  input RAM data, valid exactly 1 cycle after src_re
- pix_valid  out  1  pixel stream to kernel valid
- pix_data  out  PIX_W  pixel to kernel
- pix_ready  in  1  kernel accepts pixel
- proc_valid  in  1  kernel result valid
- proc_data  in  PIX_W  kernel result
- proc_ready  out  1  controller accepts result
- dst_we  out  1  output RAM write enable
- dst_addr  out  ADDR_W  output RAM write address
- dst_wdata  out  PIX_W  output RAM write data

Behaviour:
- Clock is clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; all counters cleared; skid FIFO emptied; in-flight flag cleared.
  - busy=0, done=0, src_re=0, pix_valid=0, proc_ready=0, dst_we=0.
  - cycle_count=0; addresses=0.
  - Reset mid-frame aborts immediately; the next start begins a fresh frame.
- SIZE = WIDTH*HEIGHT. A read, accept or write "fires" on a cycle.
- State machine:
  - IDLE -> RUN on start=1. On that edge: rd_cnt, wr_cnt, row, col and cycle_count are cleared, and zero_border is latched.
  - RUN -> DRAIN on the edge after which rd_cnt==SIZE.
  - DRAIN -> DONE on the edge after which wr_cnt==SIZE. RUN also goes directly to DONE if both conditions are met together.
  - DONE -> IDLE unconditionally. done=1 only in DONE.
  - start is ignored outside IDLE.
- cycle_count increments every cycle in RUN or DRAIN and holds its value in DONE/IDLE until the next accepted start.
- Read issue, RUN only:
  - src_re=1 when rd_cnt<SIZE and (fifo_count + inflight - pop) < 2, where pop = pix_valid & pix_ready.
  - src_addr=rd_cnt; rd_cnt increments on issue.
  - inflight is 1 in the cycle after an issue; src_rdata is pushed into the FIFO that cycle.
- Skid FIFO:
  - Depth 2, registered storage; pix_valid = (fifo_count != 0); pix_data = head entry.
  - Simultaneous push and pop keeps the count unchanged.
  - The credit rule guarantees no overflow; overflow is an assertion failure.
- Steady-state throughput: 1 pixel/cycle when pix_ready=1 continuously.
- Write side:
  - proc_ready = busy & (wr_cnt < SIZE).
  - dst_we = proc_valid & proc_ready; dst_addr = wr_cnt.
  - row/col track the write position: col wraps at WIDTH-1 to 0 and increments row.
- Border rule: if the latched zero_border=1 and (row==0 | row==HEIGHT-1 | col==0 | col==WIDTH-1), dst_wdata=0. Otherwise dst_wdata=proc_data.
- Extra kernel outputs after SIZE writes are not accepted (proc_ready=0).
- Latency: first pix_valid occurs 2 cycles after the first src_re.

Decomposition:
- Package img_pkg holds:
  - WIDTH, HEIGHT, SIZE, PIX_W, ADDR_W constants;
  - ctrl_state_t enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module, skid_fifo2: 2-entry push/pop FIFO with count output and an overflow assertion.

Test Plan:
- Identity kernel (proc = pix combinationally, pix_ready=1), zero_border=0, 76800-pixel frame -> dst equals src; done pulses once; cycle_count == 76802.
- Same setup, pix_ready pseudo-random 50% duty -> dst equals src exactly; FIFO never overflows; src_re never fires with fifo_count+inflight-pop == 2.
- zero_border=1, identity kernel -> dst[0]=0, dst[319]=0, dst[320]=0, dst[639]=0, dst[76799]=0; dst[321]=src[321].
- start pulsed again while busy -> ignored; cycle_count is unaffected; exactly one done pulse.
- rst_n=0 for one cycle when wr_cnt==1000 -> next cycle busy=0, dst_we=0, src_re=0; a new start completes a full correct frame.
- Kernel with 5-cycle pipeline and proc_valid stalls -> state stays DRAIN until the 76800th write, then DONE for one cycle, then IDLE.

Source files
------------

// File: rtl/img_pkg.sv
// Shared constants and state type for the frame streaming datapath.
package img_pkg;

   localparam int WIDTH  = 320;
   localparam int HEIGHT = 240;
   localparam int SIZE   = WIDTH * HEIGHT;
   localparam int PIX_W  = 8;
   localparam int ADDR_W = 17;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } ctrl_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry registered FIFO between the source RAM read port and the kernel input.
// Occupancy is exposed so the read issuer can run a credit check against it.
module skid_fifo2
   import img_pkg::*;
#(
   parameter int W = PIX_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   output logic [1:0]   o_count
);

   logic [W-1:0] r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;
   logic         w_pop;

   assign w_pop = i_pop & (r_count != 2'd0);

   // entry storage, written at the write pointer on every push
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // pointer and occupancy bookkeeping; push+pop together leaves the count unchanged
   always_ff @(posedge clk) begin
      if (!rst_n || i_clr) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_valid = (r_count != 2'd0);
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_push && !w_pop && (r_count == 2'd2)));

endmodule

// File: rtl/frame_stream_controller.sv
// Streams one frame from the source RAM through the kernel into the destination RAM.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | issuing source reads and accepting kernel results
//   DRAIN | all reads issued, still collecting kernel results
//   DONE  | frame fully written, one-cycle done pulse
module frame_stream_controller #(
   parameter int WIDTH  = img_pkg::WIDTH,
   parameter int HEIGHT = img_pkg::HEIGHT,
   parameter int PIX_W  = img_pkg::PIX_W,
   parameter int ADDR_W = img_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              zero_border,
   output logic              busy,
   output logic              done,
   output logic [31:0]       cycle_count,
   output logic              src_re,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [PIX_W-1:0]  src_rdata,
   output logic              pix_valid,
   output logic [PIX_W-1:0]  pix_data,
   input  logic              pix_ready,
   input  logic              proc_valid,
   input  logic [PIX_W-1:0]  proc_data,
   output logic              proc_ready,
   output logic              dst_we,
   output logic [ADDR_W-1:0] dst_addr,
   output logic [PIX_W-1:0]  dst_wdata
);

   import img_pkg::*;

   // counters carry one extra bit so they can hold the full pixel count
   localparam int                CW       = ADDR_W + 1;
   localparam logic [CW-1:0]     N_PIX    = CW'(WIDTH * HEIGHT);
   localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(WIDTH - 1);
   localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(HEIGHT - 1);

   ctrl_state_t       r_state;
   ctrl_state_t       w_state_nxt;
   logic [CW-1:0]     r_rd_cnt;
   logic [CW-1:0]     r_wr_cnt;
   logic [CW-1:0]     w_rd_cnt_nxt;
   logic [CW-1:0]     w_wr_cnt_nxt;
   logic [ADDR_W-1:0] r_row;
   logic [ADDR_W-1:0] r_col;
   logic              r_zero_border;
   logic              r_inflight;
   logic [31:0]       r_cycle_count;
   logic [1:0]        w_fifo_count;
   logic [2:0]        w_credit;
   logic              w_pop;
   logic              w_run;
   logic              w_start_acc;
   logic              w_on_border;

   assign w_run = (r_state == RUN);
   assign busy  = (r_state == RUN) | (r_state == DRAIN);
   assign done  = (r_state == DONE);

   // occupancy the FIFO will have once the outstanding read lands, net of this cycle's pop
   assign w_pop    = pix_valid & pix_ready;
   assign w_credit = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign src_re   = w_run & (r_rd_cnt < N_PIX) & (w_credit < 3'd2);
   assign src_addr = r_rd_cnt[ADDR_W-1:0];

   assign proc_ready = busy & (r_wr_cnt < N_PIX);
   assign dst_we     = proc_valid & proc_ready;
   assign dst_addr   = r_wr_cnt[ADDR_W-1:0];

   assign w_on_border = (r_row == '0) | (r_row == ROW_LAST) | (r_col == '0) | (r_col == COL_LAST);
   assign dst_wdata   = (r_zero_border && w_on_border) ? '0 : proc_data;

   assign w_rd_cnt_nxt = r_rd_cnt + {{ADDR_W{1'b0}}, src_re};
   assign w_wr_cnt_nxt = r_wr_cnt + {{ADDR_W{1'b0}}, dst_we};

   assign cycle_count = r_cycle_count;

   skid_fifo2 #(.W(PIX_W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_start_acc),
      .i_push  (r_inflight),
      .i_data  (src_rdata),
      .i_pop   (w_pop),
      .o_valid (pix_valid),
      .o_data  (pix_data),
      .o_count (w_fifo_count)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // next-state decode; transitions look at the counter values after this edge
   always_comb begin
      w_state_nxt = r_state;
      w_start_acc = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = RUN;
               w_start_acc = 1'b1;
            end
         end
         RUN: begin
            if (w_rd_cnt_nxt == N_PIX) begin
               w_state_nxt = (w_wr_cnt_nxt == N_PIX) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (w_wr_cnt_nxt == N_PIX) w_state_nxt = DONE;
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // read/write counters, write raster position, frame options and cycle counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_cnt      <= '0;
         r_wr_cnt      <= '0;
         r_row         <= '0;
         r_col         <= '0;
         r_zero_border <= 1'b0;
         r_inflight    <= 1'b0;
         r_cycle_count <= '0;
      end else begin
         r_inflight <= src_re;
         if (w_start_acc) begin
            r_rd_cnt      <= '0;
            r_wr_cnt      <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_cycle_count <= '0;
            r_zero_border <= zero_border;
         end else begin
            r_rd_cnt <= w_rd_cnt_nxt;
            r_wr_cnt <= w_wr_cnt_nxt;
            if (dst_we) begin
               if (r_col == COL_LAST) begin
                  r_col <= '0;
                  r_row <= r_row + ADDR_W'(1);
               end else begin
                  r_col <= r_col + ADDR_W'(1);
               end
            end
            if (busy) r_cycle_count <= r_cycle_count + 32'd1;
         end
      end
   end

endmodule
